// File: rtl/primogen_driver.sv
// primogen_driver: initiator for the primogen go/ready/error/res handshake.
// On start it requests COUNT results (1, 2, then successive primes), judges
// each in hardware (value rules, ordering, trial division by odd divisors
// using a bit-serial restoring divider), and reports pass/fail plus a code.
// Optional macro PRIMOGEN_DRIVER_TIMEOUT_EN adds a wait-state watchdog
// (fail code 5) bounded by TIMEOUT cycles.
module primogen_driver #(
  parameter int WIDTH   = 16,
  parameter int COUNT   = 13,
  parameter int TIMEOUT = 65535
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             gen_go,
  input  logic             gen_ready,
  input  logic             gen_error,
  input  logic [WIDTH-1:0] gen_res,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [2:0]       fail_code,
  output logic [7:0]       fail_idx,
  output logic [WIDTH-1:0] last_res
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] FC_NONE   = 3'd0;
  localparam logic [2:0] FC_ERROR  = 3'd1;
  localparam logic [2:0] FC_PRIME  = 3'd2;
  localparam logic [2:0] FC_ORDER  = 3'd3;
  localparam logic [2:0] FC_INIT   = 3'd4;
  localparam logic [2:0] FC_TMO    = 3'd5;
  localparam logic [2:0] FC_NOTRDY = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE, S_SAMPLE, S_TEST, S_REQ, S_WAIT_LO, S_WAIT_HI, S_DONE
  } state_t;

  // Sub-phase inside TEST: rule check, divisor-square bound, divide.
  typedef enum logic [1:0] {T_CHECK, T_SQ, T_DIV} tph_t;

  state_t state_q, state_d;
  tph_t   tph_q, tph_d;

  logic [7:0]       idx_q, idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [2:0]       fcode_q, fcode_d;
  logic [7:0]       fidx_q, fidx_d;
  logic [WIDTH-1:0] last_res_q, last_res_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] d_q, d_d;       // current trial divisor
  logic [WIDTH-1:0] rem_q, rem_d;   // partial remainder
  logic [WIDTH-1:0] quo_q, quo_d;   // dividend shifts out, quotient shifts in
  logic [CW-1:0]    bit_q, bit_d;

  // Divider step and divisor-square bound, all combinational on flops.
  logic [WIDTH:0]     rem_sh;
  logic               rem_ge;
  logic [WIDTH:0]     rem_nx;
  logic               div_last;
  logic [2*WIDTH-1:0] dsq;

  assign rem_sh   = {rem_q, quo_q[WIDTH-1]};
  assign rem_ge   = rem_sh >= {1'b0, d_q};
  assign rem_nx   = rem_ge ? (rem_sh - {1'b0, d_q}) : rem_sh;
  assign div_last = (bit_q == CW'(WIDTH - 1));
  assign dsq      = (2*WIDTH)'(d_q) * (2*WIDTH)'(d_q);

  logic tmo_hit;

`ifdef PRIMOGEN_DRIVER_TIMEOUT_EN
  logic [31:0] tmo_q, tmo_d;

  // Watchdog: cleared when a request is issued, counts while waiting.
  always_comb begin
    tmo_d = tmo_q;
    if (state_q == S_REQ) tmo_d = '0;
    else if (state_q == S_WAIT_LO || state_q == S_WAIT_HI) tmo_d = tmo_q + 32'd1;
  end

  // Watchdog counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tmo_q <= '0;
    else      tmo_q <= tmo_d;
  end

  assign tmo_hit = (tmo_q >= 32'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
  assign tmo_hit        = 1'b0;
`endif

  // Judgement of the current cycle: a failure with its code, or acceptance.
  logic       ev_fail;
  logic [2:0] ev_code;
  logic       ev_ok;

  always_comb begin
    ev_fail = 1'b0;
    ev_code = FC_NONE;
    ev_ok   = 1'b0;
    case (state_q)
      S_SAMPLE: begin
        if (idx_q == 8'd0 && !gen_ready) begin
          ev_fail = 1'b1; ev_code = FC_NOTRDY;
        end else if (gen_error) begin
          ev_fail = 1'b1; ev_code = FC_ERROR;
        end
      end
      S_TEST: begin
        case (tph_q)
          T_CHECK: begin
            if (idx_q == 8'd0) begin
              if (last_res_q == WIDTH'(1)) ev_ok = 1'b1;
              else begin ev_fail = 1'b1; ev_code = FC_INIT; end
            end else if (idx_q == 8'd1) begin
              if (last_res_q == WIDTH'(2)) ev_ok = 1'b1;
              else begin ev_fail = 1'b1; ev_code = FC_INIT; end
            end else if (last_res_q <= prev_q) begin
              ev_fail = 1'b1; ev_code = FC_ORDER;
            end else if (!last_res_q[0]) begin
              ev_fail = 1'b1; ev_code = FC_PRIME;
            end
          end
          T_SQ: if (dsq > (2*WIDTH)'(last_res_q)) ev_ok = 1'b1;
          T_DIV: begin
            if (div_last && rem_nx == '0) begin
              ev_fail = 1'b1; ev_code = FC_PRIME;
            end
          end
          default: ;
        endcase
      end
      S_WAIT_LO: if (gen_ready && tmo_hit) begin ev_fail = 1'b1; ev_code = FC_TMO; end
      S_WAIT_HI: if (!gen_ready && tmo_hit) begin ev_fail = 1'b1; ev_code = FC_TMO; end
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_SAMPLE;
      S_SAMPLE:       state_d = ev_fail ? S_DONE : S_TEST;
      S_TEST: begin
        if (ev_fail) state_d = S_DONE;
        else if (ev_ok) state_d = (idx_q == 8'(COUNT - 1)) ? S_DONE : S_REQ;
      end
      S_REQ:     state_d = S_WAIT_LO;
      S_WAIT_LO: begin
        if (!gen_ready)   state_d = S_WAIT_HI;
        else if (ev_fail) state_d = S_DONE;
      end
      S_WAIT_HI: begin
        if (gen_ready)    state_d = S_SAMPLE;
        else if (ev_fail) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: run bookkeeping, capture, divider and result latching.
  always_comb begin
    tph_d      = tph_q;
    idx_d      = idx_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    fcode_d    = fcode_q;
    fidx_d     = fidx_q;
    last_res_d = last_res_q;
    prev_d     = prev_q;
    d_d        = d_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    bit_d      = bit_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          idx_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          fcode_d = FC_NONE;
          fidx_d  = '0;
        end
      end
      S_SAMPLE: begin
        if (!ev_fail) begin
          last_res_d = gen_res;
          prev_d     = last_res_q;
          tph_d      = T_CHECK;
        end
      end
      S_TEST: begin
        case (tph_q)
          T_CHECK: begin
            d_d   = WIDTH'(3);
            tph_d = T_SQ;
          end
          T_SQ: begin
            if (!ev_ok) begin
              rem_d = '0;
              quo_d = last_res_q;
              bit_d = '0;
              tph_d = T_DIV;
            end
          end
          T_DIV: begin
            rem_d = rem_nx[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], rem_ge};
            bit_d = bit_q + CW'(1);
            if (div_last) begin
              d_d   = d_q + WIDTH'(2);
              tph_d = T_SQ;
            end
          end
          default: tph_d = T_CHECK;
        endcase
        if (ev_ok && idx_q == 8'(COUNT - 1)) begin
          pass_d = 1'b1;
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end
      S_REQ: idx_d = idx_q + 8'd1;
      default: ;
    endcase
    if (ev_fail) begin
      fcode_d = ev_code;
      fidx_d  = idx_q;
      pass_d  = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b1;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tph_q      <= T_CHECK;
      idx_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fcode_q    <= FC_NONE;
      fidx_q     <= '0;
      last_res_q <= '0;
      prev_q     <= '0;
      d_q        <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      bit_q      <= '0;
    end else begin
      tph_q      <= tph_d;
      idx_q      <= idx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      fcode_q    <= fcode_d;
      fidx_q     <= fidx_d;
      last_res_q <= last_res_d;
      prev_q     <= prev_d;
      d_q        <= d_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      bit_q      <= bit_d;
    end
  end

  // Outputs: request pulse decoded from state, status straight from flops.
  always_comb begin
    gen_go    = (state_q == S_REQ);
    busy      = busy_q;
    done      = done_q;
    pass      = pass_q;
    fail_code = fcode_q;
    fail_idx  = fidx_q;
    last_res  = last_res_q;
  end

endmodule

// File: tb/tb_primogen_driver.sv
// tb_primogen_driver: directed vectors against a behavioural primogen model.
module tb_primogen_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        gen_go;
  logic        gen_ready = 1'b0;
  logic        gen_error = 1'b0;
  logic [15:0] gen_res = '0;
  logic        busy, done, pass;
  logic [2:0]  fail_code;
  logic [7:0]  fail_idx;
  logic [15:0] last_res;

  primogen_driver #(.WIDTH(16), .COUNT(13), .TIMEOUT(100)) dut (
    .clk(clk), .rst(rst), .start(start), .gen_go(gen_go),
    .gen_ready(gen_ready), .gen_error(gen_error), .gen_res(gen_res),
    .busy(busy), .done(done), .pass(pass), .fail_code(fail_code),
    .fail_idx(fail_idx), .last_res(last_res)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Model configuration.
  int  bad_idx   = -1;
  int  bad_val   = 0;
  int  err_idx   = -1;
  int  stall_idx = -1;
  bit  rdy0      = 1'b1;
  bit  mdl_clr   = 1'b0;
  bit  cnt_clr   = 1'b0;

  function automatic logic [15:0] mval(input int i);
    logic [15:0] v;
    case (i)
      0: v = 16'd1;   1: v = 16'd2;   2: v = 16'd3;   3: v = 16'd5;
      4: v = 16'd7;   5: v = 16'd11;  6: v = 16'd13;  7: v = 16'd17;
      8: v = 16'd19;  9: v = 16'd23;  10: v = 16'd29; 11: v = 16'd31;
      12: v = 16'd37;
      default: v = 16'd0;
    endcase
    if (i == bad_idx) v = bad_val[15:0];
    return v;
  endfunction

  // Behavioural primogen: ready drops for 3 cycles after each go.
  int m_idx = 0;
  int m_cnt = 0;
  always @(posedge clk) begin
    if (mdl_clr) begin
      m_idx     <= 0;
      m_cnt     <= 0;
      gen_ready <= rdy0;
      gen_res   <= mval(0);
      gen_error <= (err_idx == 0);
    end else if (gen_go) begin
      m_idx     <= m_idx + 1;
      m_cnt     <= 3;
      gen_ready <= 1'b0;
      gen_error <= 1'b0;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1 && m_idx != stall_idx) begin
        gen_ready <= 1'b1;
        gen_res   <= mval(m_idx);
        gen_error <= (m_idx == err_idx);
      end
    end
  end

  // gen_go pulse counter and width monitor.
  int  go_cnt = 0;
  int  go_wide = 0;
  logic go_prev = 1'b0;
  always @(posedge clk) begin
    if (cnt_clr) begin
      go_cnt  <= 0;
      go_wide <= 0;
    end else begin
      if (gen_go) go_cnt <= go_cnt + 1;
      if (gen_go && go_prev) go_wide <= go_wide + 1;
    end
    go_prev <= gen_go;
  end

  task automatic launch(input int bi, input int bv, input int ei, input int si, input bit r0);
    bad_idx = bi; bad_val = bv; err_idx = ei; stall_idx = si; rdy0 = r0;
    @(negedge clk); mdl_clr = 1'b1; cnt_clr = 1'b1;
    @(negedge clk); mdl_clr = 1'b0; cnt_clr = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    for (int i = 0; i < lim; i++) begin
      if (done) break;
      @(negedge clk);
    end
    chk("done_in_time", done, 1);
  endtask

  task automatic chk_zero_outs(input string tag);
    chk({tag, "_go"},   gen_go,    0);
    chk({tag, "_busy"}, busy,      0);
    chk({tag, "_done"}, done,      0);
    chk({tag, "_pass"}, pass,      0);
    chk({tag, "_code"}, fail_code, 0);
    chk({tag, "_idx"},  fail_idx,  0);
    chk({tag, "_res"},  last_res,  0);
  endtask

  task automatic clean_pass(input string tag);
    wait_done(3000);
    chk({tag, "_pass"}, pass,      1);
    chk({tag, "_busy"}, busy,      0);
    chk({tag, "_code"}, fail_code, 0);
    chk({tag, "_fidx"}, fail_idx,  0);
    chk({tag, "_res"},  last_res,  37);
    chk({tag, "_gos"},  go_cnt,    12);
    chk({tag, "_wide"}, go_wide,   0);
  endtask

  initial begin
    // Reset state.
    repeat (3) @(negedge clk);
    chk_zero_outs("rst");
    rst = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    // Clean run, with a start pulse mid-run that must be ignored.
    launch(-1, 0, -1, -1, 1'b1);
    chk("run_busy", busy, 1);
    chk("run_done", done, 0);
    repeat (20) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    clean_pass("clean");

    // 25 in place of 23 at idx 9: composite.
    launch(9, 25, -1, -1, 1'b1);
    wait_done(3000);
    chk("c25_pass", pass,      0);
    chk("c25_code", fail_code, 2);
    chk("c25_idx",  fail_idx,  9);
    repeat (50) @(negedge clk);
    chk("c25_gos",  go_cnt,    9);
    chk("c25_busy", busy,      0);

    // 0 at idx 0: bad initial value.
    launch(0, 0, -1, -1, 1'b1);
    wait_done(3000);
    chk("init_code", fail_code, 4);
    chk("init_idx",  fail_idx,  0);
    chk("init_gos",  go_cnt,    0);

    // 7 repeated at idx 5: not increasing.
    launch(5, 7, -1, -1, 1'b1);
    wait_done(3000);
    chk("rep_code", fail_code, 3);
    chk("rep_idx",  fail_idx,  5);
    chk("rep_res",  last_res,  7);

    // Even value at idx 6 (14 > 11): not prime.
    launch(6, 14, -1, -1, 1'b1);
    wait_done(3000);
    chk("even_code", fail_code, 2);
    chk("even_idx",  fail_idx,  6);

    // gen_error with ready at idx 4.
    launch(-1, 0, 4, -1, 1'b1);
    wait_done(3000);
    chk("err_code", fail_code, 1);
    chk("err_idx",  fail_idx,  4);
    chk("err_pass", pass,      0);

    // Generator not ready at start.
    launch(-1, 0, -1, -1, 1'b0);
    wait_done(100);
    chk("nrdy_code", fail_code, 6);
    chk("nrdy_idx",  fail_idx,  0);

    // Reset asserted while the idx 9 value is under trial division.
    launch(-1, 0, -1, -1, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      if (go_cnt == 9) break;
      @(negedge clk);
    end
    chk("mid_gos", go_cnt, 9);
    repeat (8) @(negedge clk);
    rst = 1'b0;
    #1;
    chk_zero_outs("midrst");
    @(negedge clk);
    rst = 1'b1;
    launch(-1, 0, -1, -1, 1'b1);
    clean_pass("after_rst");

    // Generator never raises ready again after idx 3.
    launch(-1, 0, -1, 4, 1'b1);
`ifdef PRIMOGEN_DRIVER_TIMEOUT_EN
    wait_done(400);
    chk("tmo_code", fail_code, 5);
    chk("tmo_idx",  fail_idx,  4);
    chk("tmo_gos",  go_cnt,    4);
`else
    repeat (400) @(negedge clk);
    chk("stall_busy", busy,   1);
    chk("stall_done", done,   0);
    chk("stall_gos",  go_cnt, 4);
`endif
    rst = 1'b0;
    #1;
    chk_zero_outs("end_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
